// File: rtl/calc_rf_pkg.sv
// Shared types and default sizes for the calculator register file.
// No logic; imported by the register file and its clear controller.
// Defaults match the calculator datapath operand width and register count.
package calc_rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DW = 16;
    localparam int RF_AW = 2;

endpackage

// File: rtl/regfile_mp_clr_ctl.sv
// Bulk-clear sequencer: walks clr_idx over every register, one per cycle.
// Latency: busy the edge after clr is seen low, for DEPTH cycles, then a 1-cycle clr_done.
// Backpressure: none; requests during a clear are ignored, a held clr restarts right after done.
module regfile_mp_clr_ctl
    import calc_rf_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic          ck,
    input  logic          res,
    input  logic          clr,
    output logic          busy,
    output logic          clr_done,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = '1;

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (!clr) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_en   = busy;
    assign clr_idx  = cnt_q;
    assign clr_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one active-low write port, two combinational read ports, bulk clear.
// Latency: writes land on the next edge; reads are combinational (optionally bypassing the write).
// Backpressure: writes are dropped while clearing or when a clear is requested the same cycle.
module regfile_mp
    import calc_rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int AW     = RF_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic                   ck,
    input  logic                   res,
    input  logic [DW-1:0]          d,
    input  logic [AW-1:0]          wsel,
    input  logic                   we,
    input  logic [AW-1:0]          rsel_a,
    input  logic [AW-1:0]          rsel_b,
    input  logic                   clr,
    output logic [DW-1:0]          q_a,
    output logic [DW-1:0]          q_b,
    output logic                   busy,
    output logic                   clr_done,
    output logic [DW*(2**AW)-1:0]  r_all
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic          clr_en;
    logic [AW-1:0] clr_idx;
    logic          wr_en;

    regfile_mp_clr_ctl #(
        .AW (AW)
    ) u_clr_ctl (
        .ck       (ck),
        .res      (res),
        .clr      (clr),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx)
    );

    // A clear request in IDLE takes priority over a write in the same cycle.
    assign wr_en = !busy && clr && !we;

    always_comb begin
        regs_d = regs_q;
        if (clr_en) begin
            regs_d[clr_idx] = '0;
        end else if (wr_en) begin
            regs_d[wsel] = d;
        end
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign q_a = (BYPASS && wr_en && (rsel_a == wsel)) ? d : regs_q[rsel_a];
    assign q_b = (BYPASS && wr_en && (rsel_b == wsel)) ? d : regs_q[rsel_b];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_r_all
        assign r_all[gi*DW +: DW] = regs_q[gi];
    end

endmodule
